// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding and default sizes for the registered
// 1-to-8 demultiplexer / serial-to-parallel capture block.
package demux_pkg;

    localparam int N_OUT_DEF = 8;
    localparam int SEL_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/demux_1_8_reg_sel_counter.sv
// sel_counter: modulo-N up counter with synchronous clear, count enable and a
// terminal-count flag. Provides the lane address during auto capture.
module sel_counter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

    // Next count: clear wins over enable; wrap from N-1 back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_1_8_reg.sv
// demux_1_8_reg: registered 1-to-8 demultiplexer with manual addressed writes
// and counter-driven frame capture presented on a valid/ready handshake.
// Optional feature macro: DEMUX_PARITY_EN (adds an even-parity bit per frame).
module demux_1_8_reg
    import demux_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [SEL_W-1:0] select,
    input  logic             auto_mode,
    input  logic             start,
    output logic [N_OUT-1:0] y_out,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [SEL_W-1:0] cur_sel,
    output logic             busy,
    output logic             par_err
);

    state_t             state_q;
    state_t             state_d;
    logic [N_OUT-1:0]   y_out_q;
    logic [N_OUT-1:0]   y_out_d;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
`ifdef DEMUX_PARITY_EN
    logic               par_err_q;
    logic               par_err_d;
`endif

    sel_counter #(
        .N (N_OUT),
        .W (SEL_W)
    ) u_sel_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (cur_sel),
        .tc  (cnt_tc)
    );

    assign y_out       = y_out_q;
    assign frame_valid = (state_q == ST_HOLD);
    assign d_ready     = (state_q != ST_HOLD);
    assign busy        = (state_q != ST_IDLE);
`ifdef DEMUX_PARITY_EN
    assign par_err     = par_err_q;
`else
    assign par_err     = 1'b0;
`endif

    // Next-state, lane-write and counter-control decode.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
        state_d   = state_q;
        y_out_d   = y_out_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
`ifdef DEMUX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (auto_mode) begin
                    // Data bits without a start are dropped; y_out is kept.
                    if (start) begin
                        state_d = ST_SHIFT;
                        cnt_clr = 1'b1;
`ifdef DEMUX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end
                end else if (d_valid) begin
                    y_out_d[select] = d_in;
                end
            end
            ST_SHIFT: begin
                if (d_valid) begin
                    y_out_d[cur_sel] = d_in;
                    cnt_en           = 1'b1;
                    if (cnt_tc) begin
`ifdef DEMUX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_HOLD;
`endif
                    end
                end
            end
            ST_PARITY: begin
`ifdef DEMUX_PARITY_EN
                // Even parity: data XOR parity bit must be zero.
                if (d_valid) begin
                    par_err_d = (^y_out_q) ^ d_in;
                    state_d   = ST_HOLD;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_HOLD: begin
                if (frame_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, lane and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            y_out_q   <= '0;
`ifdef DEMUX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            y_out_q   <= y_out_d;
`ifdef DEMUX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_demux_1_8_reg.sv
// tb_demux_1_8_reg: directed self-checking bench for demux_1_8_reg.
// Honours DEMUX_PARITY_EN when defined for the build.
module tb_demux_1_8_reg;

`ifdef DEMUX_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       d_in;
    logic       d_valid;
    logic       d_ready;
    logic [2:0] select;
    logic       auto_mode;
    logic       start;
    logic [7:0] y_out;
    logic       frame_valid;
    logic       frame_ready;
    logic [2:0] cur_sel;
    logic       busy;
    logic       par_err;

    int tests = 0;
    int fails = 0;

    demux_1_8_reg dut (
        .clk         (clk),
        .rst         (rst),
        .d_in        (d_in),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .select      (select),
        .auto_mode   (auto_mode),
        .start       (start),
        .y_out       (y_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .cur_sel     (cur_sel),
        .busy        (busy),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled and inputs driven 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a capture and feed data LSB-first; gap_after[i] inserts one idle
    // cycle after bit i. Sends the parity bit when parity is built in.
    // Returns after the edge that should enter HOLD.
    task automatic do_frame(input logic [7:0] data, input logic [7:0] gap_after,
                            input logic par_bit);
        auto_mode = 1'b1;
        start     = 1'b1;
        d_valid   = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d_in    = data[i];
            d_valid = 1'b1;
            if (i == 7 && EXTRA == 0) begin
                tests++;
                if (frame_valid !== 1'b0) begin
                    $display("FAIL fv_early: frame_valid=%b required 0", frame_valid);
                    fails++;
                end
            end
            tick();
            if (gap_after[i]) begin
                d_valid = 1'b0;
                d_in    = ~d_in;
                tick();
            end
        end
        if (EXTRA == 1) begin
            d_in    = par_bit;
            d_valid = 1'b1;
            tests++;
            if (frame_valid !== 1'b0) begin
                $display("FAIL fv_early_par: frame_valid=%b required 0", frame_valid);
                fails++;
            end
            tick();
        end
        d_valid = 1'b0;
    endtask

    // Accept the held frame and confirm frame_valid drops after one edge.
    task automatic release_frame();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        tests++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL release: frame_valid=%b busy=%b required 0 0", frame_valid, busy);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (y_out !== 8'h00) begin $display("FAIL rst_y: y_out=%h required 00", y_out); fails++; end
        tests++;
        if (frame_valid !== 1'b0) begin $display("FAIL rst_fv: frame_valid=%b required 0", frame_valid); fails++; end
        tests++;
        if (cur_sel !== 3'd0) begin $display("FAIL rst_sel: cur_sel=%0d required 0", cur_sel); fails++; end
        tests++;
        if (busy !== 1'b0) begin $display("FAIL rst_busy: busy=%b required 0", busy); fails++; end
        tests++;
        if (par_err !== 1'b0) begin $display("FAIL rst_par: par_err=%b required 0", par_err); fails++; end
        tests++;
        if (d_ready !== 1'b1) begin $display("FAIL rst_rdy: d_ready=%b required 1", d_ready); fails++; end
    endtask

    task automatic test_manual();
        auto_mode = 1'b0;
        select    = 3'b101;
        d_in      = 1'b1;
        d_valid   = 1'b1;
        tick();
        d_valid = 1'b0;
        tests++;
        if (y_out !== 8'h20) begin $display("FAIL man_5: y_out=%h required 20", y_out); fails++; end
        select  = 3'd0;
        d_valid = 1'b1;
        tick();
        tests++;
        if (y_out !== 8'h21) begin $display("FAIL man_0: y_out=%h required 21", y_out); fails++; end
        select = 3'd5;
        d_in   = 1'b0;
        tick();
        d_valid = 1'b0;
        tests++;
        if (y_out !== 8'h01) begin $display("FAIL man_clr5: y_out=%h required 01", y_out); fails++; end
        // Auto mode without start drops the bit.
        auto_mode = 1'b1;
        select    = 3'd7;
        d_in      = 1'b1;
        d_valid   = 1'b1;
        tick();
        d_valid = 1'b0;
        tests++;
        if (y_out !== 8'h01 || busy !== 1'b0) begin
            $display("FAIL drop: y_out=%h busy=%b required 01 0", y_out, busy); fails++;
        end
        // Start with auto_mode low is ignored.
        auto_mode = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b0) begin $display("FAIL start_man: busy=%b required 0", busy); fails++; end
    endtask

    task automatic test_auto_frame();
        logic [7:0] data;
        data      = 8'h4F;
        auto_mode = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (busy !== 1'b1 || cur_sel !== 3'd0) begin
            $display("FAIL af_start: busy=%b cur_sel=%0d required 1 0", busy, cur_sel); fails++;
        end
        for (int i = 0; i < 8; i++) begin
            d_in    = data[i];
            d_valid = 1'b1;
            tick();
            if (i == 2) begin
                tests++;
                if (cur_sel !== 3'd3) begin $display("FAIL af_sel3: cur_sel=%0d required 3", cur_sel); fails++; end
            end
            if (i == 6) begin
                tests++;
                if (frame_valid !== 1'b0) begin $display("FAIL af_c8: frame_valid=%b required 0", frame_valid); fails++; end
            end
        end
        if (EXTRA == 1) begin
            d_in = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        tests++;
        if (frame_valid !== 1'b1) begin $display("FAIL af_fv: frame_valid=%b required 1", frame_valid); fails++; end
        tests++;
        if (y_out !== 8'h4F) begin $display("FAIL af_y: y_out=%h required 4f", y_out); fails++; end
        tests++;
        if (cur_sel !== 3'd0 || d_ready !== 1'b0) begin
            $display("FAIL af_hold: cur_sel=%0d d_ready=%b required 0 0", cur_sel, d_ready); fails++;
        end
        tests++;
        if (par_err !== 1'b0) begin $display("FAIL af_par: par_err=%b required 0", par_err); fails++; end
        release_frame();
    endtask

    task automatic test_backpressure();
        do_frame(8'h98, 8'b0010_0100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            d_in    = 1'b1;
            d_valid = 1'b1;
            tick();
            tests++;
            if (frame_valid !== 1'b1 || y_out !== 8'h98 || d_ready !== 1'b0) begin
                $display("FAIL bp_hold%0d: fv=%b y_out=%h rdy=%b required 1 98 0",
                         k, frame_valid, y_out, d_ready);
                fails++;
            end
        end
        d_valid = 1'b0;
        release_frame();
        tests++;
        if (y_out !== 8'h98) begin $display("FAIL bp_keep: y_out=%h required 98", y_out); fails++; end
    endtask

    task automatic test_ignored();
        logic [7:0] data;
        data      = 8'hC3;
        auto_mode = 1'b1;
        start     = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            d_in      = data[i];
            d_valid   = 1'b1;
            start     = (i == 3);
            auto_mode = (i != 5);
            select    = 3'd7;
            tick();
        end
        start     = 1'b0;
        auto_mode = 1'b1;
        if (EXTRA == 1) begin
            d_in = 1'b0;
            tick();
        end
        d_valid = 1'b0;
        tests++;
        if (frame_valid !== 1'b1 || y_out !== 8'hC3) begin
            $display("FAIL ign: fv=%b y_out=%h required 1 c3", frame_valid, y_out); fails++;
        end
        release_frame();
    endtask

    task automatic test_reset_mid();
        auto_mode = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_in    = 1'b1;
            d_valid = 1'b1;
            tick();
        end
        d_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (y_out !== 8'h00 || busy !== 1'b0 || cur_sel !== 3'd0 || frame_valid !== 1'b0) begin
            $display("FAIL rmid: y_out=%h busy=%b sel=%0d fv=%b required 00 0 0 0",
                     y_out, busy, cur_sel, frame_valid);
            fails++;
        end
        do_frame(8'hA5, 8'h00, 1'b0);
        tests++;
        if (frame_valid !== 1'b1 || y_out !== 8'hA5) begin
            $display("FAIL rmid_a5: fv=%b y_out=%h required 1 a5", frame_valid, y_out); fails++;
        end
        release_frame();
    endtask

    task automatic test_parity();
`ifdef DEMUX_PARITY_EN
        do_frame(8'h4F, 8'h00, 1'b1);
        tests++;
        if (par_err !== 1'b0) begin $display("FAIL par_ok: par_err=%b required 0", par_err); fails++; end
        release_frame();
        do_frame(8'h4F, 8'h00, 1'b0);
        tests++;
        if (par_err !== 1'b1) begin $display("FAIL par_bad: par_err=%b required 1", par_err); fails++; end
        release_frame();
        tests++;
        if (par_err !== 1'b1) begin $display("FAIL par_keep: par_err=%b required 1", par_err); fails++; end
        auto_mode = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (par_err !== 1'b0) begin $display("FAIL par_clr: par_err=%b required 0", par_err); fails++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`else
        do_frame(8'h4F, 8'h00, 1'b0);
        tests++;
        if (par_err !== 1'b0 || y_out !== 8'h4F) begin
            $display("FAIL par_off: par_err=%b y_out=%h required 0 4f", par_err, y_out); fails++;
        end
        release_frame();
`endif
    endtask

    initial begin
        rst         = 1'b1;
        d_in        = 1'b0;
        d_valid     = 1'b0;
        select      = 3'd0;
        auto_mode   = 1'b0;
        start       = 1'b0;
        frame_ready = 1'b0;
        test_reset();
        test_manual();
        test_auto_frame();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
